// File: rtl/udma_hyper_twd_splitter.sv
// udma_hyper_twd_splitter
// Pops packed Hyperbus transaction commands and issues them as a sequence of
// contiguous sub-transactions. The transfer is split at row boundaries when 2D
// mode is active on the Hyper side, the L2 side, or both.

module udma_hyper_twd_splitter #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  localparam int CMD_W = L2_AWIDTH_NOAL*2 + TRANS_SIZE*6 + 32 + 16 + 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic [CMD_W-1:0]          trans_cmd_data_i,
  input  logic                      trans_cmd_valid_i,
  output logic                      trans_cmd_ready_o,

  output logic [31:0]               sub_hyper_addr_o,
  output logic [L2_AWIDTH_NOAL-1:0] sub_l2_addr_o,
  output logic [TRANS_SIZE-1:0]     sub_len_o,
  output logic                      sub_rw_o,
  output logic                      sub_addr_space_o,
  output logic                      sub_burst_type_o,
  output logic [15:0]               sub_intreg_o,
  output logic                      sub_last_o,
  output logic                      sub_valid_o,
  input  logic                      sub_ready_i,

  output logic                      trans_done_o,
  output logic                      busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Unpacked command fields
  logic [L2_AWIDTH_NOAL-1:0] cmd_rx_start;
  logic [TRANS_SIZE-1:0]     cmd_rx_size;
  logic [L2_AWIDTH_NOAL-1:0] cmd_tx_start;
  logic [TRANS_SIZE-1:0]     cmd_tx_size;
  logic [31:0]               cmd_hyper_addr;
  logic [15:0]               cmd_intreg;
  logic                      cmd_rw;
  logic                      cmd_addr_space;
  logic                      cmd_burst_type;
  logic                      cmd_ext_act;
  logic [TRANS_SIZE-1:0]     cmd_ext_count;
  logic [TRANS_SIZE-1:0]     cmd_ext_stride;
  logic                      cmd_l2_act;
  logic [TRANS_SIZE-1:0]     cmd_l2_count;
  logic [TRANS_SIZE-1:0]     cmd_l2_stride;

  // Values selected by the read/write direction of the incoming command
  logic [L2_AWIDTH_NOAL-1:0] sel_l2_start;
  logic [TRANS_SIZE-1:0]     sel_total;

  // Transfer state
  state_t                    state;
  logic [TRANS_SIZE-1:0]     remaining;
  logic [31:0]               hyper_row_base;
  logic [31:0]               hyper_addr;
  logic [TRANS_SIZE-1:0]     ext_row_rem;
  logic [L2_AWIDTH_NOAL-1:0] l2_row_base;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr;
  logic [TRANS_SIZE-1:0]     l2_row_rem;

  // Latched sideband and 2D geometry
  logic                      ext_en;
  logic                      l2_en;
  logic [TRANS_SIZE-1:0]     ext_count_q;
  logic [TRANS_SIZE-1:0]     ext_stride_q;
  logic [TRANS_SIZE-1:0]     l2_count_q;
  logic [TRANS_SIZE-1:0]     l2_stride_q;
  logic                      rw_q;
  logic                      addr_space_q;
  logic                      burst_type_q;
  logic [15:0]               intreg_q;

  // Registered handshake outputs
  logic                      sub_valid_q;
  logic                      cmd_ready_q;
  logic                      done_q;

  // Combinational chunk and next-address values
  logic [TRANS_SIZE-1:0]     chunk;
  logic                      is_last;
  logic [TRANS_SIZE-1:0]     ext_rem_dec;
  logic [TRANS_SIZE-1:0]     l2_rem_dec;
  logic [31:0]               hyper_base_next;
  logic [31:0]               hyper_addr_next;
  logic [TRANS_SIZE-1:0]     ext_rem_next;
  logic [L2_AWIDTH_NOAL-1:0] l2_base_next;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr_next;
  logic [TRANS_SIZE-1:0]     l2_rem_next;

  assign {cmd_rx_start, cmd_rx_size, cmd_tx_start, cmd_tx_size,
          cmd_hyper_addr, cmd_intreg, cmd_rw, cmd_addr_space, cmd_burst_type,
          cmd_ext_act, cmd_ext_count, cmd_ext_stride,
          cmd_l2_act, cmd_l2_count, cmd_l2_stride} = trans_cmd_data_i;

  assign sel_l2_start = cmd_rw ? cmd_rx_start : cmd_tx_start;
  assign sel_total    = cmd_rw ? cmd_rx_size  : cmd_tx_size;

  // Largest contiguous piece: bounded by what is left overall and by the
  // remainder of the current row on each side running in 2D mode
  always_comb begin
    chunk = remaining;
    if (ext_en && (ext_row_rem < chunk)) begin
      chunk = ext_row_rem;
    end
    if (l2_en && (l2_row_rem < chunk)) begin
      chunk = l2_row_rem;
    end
  end

  // The last flag is only meaningful while a sub-transaction is presented;
  // idle registers would otherwise compare 0 == 0
  assign is_last = (state == ISSUE) && (chunk == remaining);

  // Hyper-side address advance: jump to the next row start when the row is
  // exhausted, otherwise continue linearly; arithmetic wraps at 32 bits
  always_comb begin
    ext_rem_dec     = ext_row_rem - chunk;
    hyper_base_next = hyper_row_base;
    hyper_addr_next = hyper_addr + 32'(chunk);
    ext_rem_next    = ext_row_rem;
    if (ext_en) begin
      ext_rem_next = ext_rem_dec;
      if (ext_rem_dec == '0) begin
        hyper_base_next = hyper_row_base + 32'(ext_stride_q);
        hyper_addr_next = hyper_row_base + 32'(ext_stride_q);
        ext_rem_next    = ext_count_q;
      end
    end
  end

  // L2-side address advance, same scheme, wrapping at the L2 address width
  always_comb begin
    l2_rem_dec   = l2_row_rem - chunk;
    l2_base_next = l2_row_base;
    l2_addr_next = l2_addr + L2_AWIDTH_NOAL'(chunk);
    l2_rem_next  = l2_row_rem;
    if (l2_en) begin
      l2_rem_next = l2_rem_dec;
      if (l2_rem_dec == '0) begin
        l2_base_next = l2_row_base + L2_AWIDTH_NOAL'(l2_stride_q);
        l2_addr_next = l2_row_base + L2_AWIDTH_NOAL'(l2_stride_q);
        l2_rem_next  = l2_count_q;
      end
    end
  end

  // Command accept / sub-transaction issue state machine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      remaining      <= '0;
      hyper_row_base <= '0;
      hyper_addr     <= '0;
      ext_row_rem    <= '0;
      l2_row_base    <= '0;
      l2_addr        <= '0;
      l2_row_rem     <= '0;
      ext_en         <= 1'b0;
      l2_en          <= 1'b0;
      ext_count_q    <= '0;
      ext_stride_q   <= '0;
      l2_count_q     <= '0;
      l2_stride_q    <= '0;
      rw_q           <= 1'b0;
      addr_space_q   <= 1'b0;
      burst_type_q   <= 1'b0;
      intreg_q       <= '0;
      sub_valid_q    <= 1'b0;
      cmd_ready_q    <= 1'b1;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trans_cmd_valid_i) begin
            remaining      <= sel_total;
            hyper_row_base <= cmd_hyper_addr;
            hyper_addr     <= cmd_hyper_addr;
            ext_row_rem    <= cmd_ext_count;
            l2_row_base    <= sel_l2_start;
            l2_addr        <= sel_l2_start;
            l2_row_rem     <= cmd_l2_count;
            ext_en         <= cmd_ext_act && (cmd_ext_count != '0);
            l2_en          <= cmd_l2_act && (cmd_l2_count != '0);
            ext_count_q    <= cmd_ext_count;
            ext_stride_q   <= cmd_ext_stride;
            l2_count_q     <= cmd_l2_count;
            l2_stride_q    <= cmd_l2_stride;
            rw_q           <= cmd_rw;
            addr_space_q   <= cmd_addr_space;
            burst_type_q   <= cmd_burst_type;
            intreg_q       <= cmd_intreg;
            if (sel_total != '0) begin
              state       <= ISSUE;
              sub_valid_q <= 1'b1;
              cmd_ready_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (sub_ready_i) begin
            remaining      <= remaining - chunk;
            hyper_row_base <= hyper_base_next;
            hyper_addr     <= hyper_addr_next;
            ext_row_rem    <= ext_rem_next;
            l2_row_base    <= l2_base_next;
            l2_addr        <= l2_addr_next;
            l2_row_rem     <= l2_rem_next;
            if (is_last) begin
              state       <= IDLE;
              sub_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          sub_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign trans_cmd_ready_o = cmd_ready_q;
  assign sub_valid_o       = sub_valid_q;
  assign trans_done_o      = done_q;
  assign busy_o            = (state == ISSUE);

  assign sub_hyper_addr_o  = hyper_addr;
  assign sub_l2_addr_o     = l2_addr;
  assign sub_len_o         = chunk;
  assign sub_last_o        = is_last;
  assign sub_rw_o          = rw_q;
  assign sub_addr_space_o  = addr_space_q;
  assign sub_burst_type_o  = burst_type_q;
  assign sub_intreg_o      = intreg_q;

endmodule
